// File: rtl/bus_fabric.sv
// bus_fabric -- memory-mapped interconnect between the CPU bus master and up
// to NUM_REGIONS subordinates (boot ROM, WRAM banks, AVR bridge, LED/GPIO).
// Registered decode, registered read mux, per-region wait states with a
// subordinate ready handshake, and a timeout/fault monitor with open-bus reads.
//
// Ports:
//   clk, rst        bus clock; synchronous active-high reset
//   m_addr/m_wdata  master address / write data (latched at request)
//   m_rd/m_wr       master request, held until m_ready
//   m_rdata         registered read data, valid while m_ready=1
//   m_ready         one-cycle completion pulse
//   m_fault         one-cycle fault pulse, coincident with m_ready
//   s_sel           one-hot registered subordinate select
//   s_addr/s_wdata  latched address / write data to subordinates
//   s_rd/s_wr       latched strobes, qualified by s_sel
//   s_rdata         per-region read data, region i at [i*DATA_W +: DATA_W]
//   s_ready         per-region ready; tie high for fixed-latency subordinates
//   fault_count     saturating count of faults since reset
//
// Timing: request seen in cycle T -> s_sel from T+1 -> m_ready at T+2 for a
// zero-wait, always-ready subordinate; each wait/not-ready cycle adds one.

module bus_fabric #(
  parameter int unsigned                   NUM_REGIONS = 4,
  parameter int unsigned                   ADDR_W      = 16,
  parameter int unsigned                   DATA_W      = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hFFFF, 16'hD000, 16'hC000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFFFF, 16'hF000, 16'hF000, 16'hC000},
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT = {4'd0, 4'd1, 4'd1, 4'd1},
  parameter int unsigned                   TIMEOUT     = 16,
  parameter logic [DATA_W-1:0]             OPEN_BUS    = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst,
  // master side
  input  logic [ADDR_W-1:0]             m_addr,
  input  logic [DATA_W-1:0]             m_wdata,
  input  logic                          m_rd,
  input  logic                          m_wr,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_ready,
  output logic                          m_fault,
  // subordinate side
  output logic [NUM_REGIONS-1:0]        s_sel,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_rd,
  output logic                          s_wr,
  input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
  input  logic [NUM_REGIONS-1:0]        s_ready,
  // status
  output logic [7:0]                    fault_count
);

  localparam int unsigned IDX_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  // Counter must hold TIMEOUT-1 and be at least as wide as a 4-bit wait value.
  localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_RAW > 4) ? CNT_RAW : 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_REGIONS-1:0] r_sel;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic                   r_s_rd;
  logic                   r_s_wr;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_ready;
  logic                   r_fault;
  logic [7:0]             r_fault_count;

  logic                   w_hit;
  logic [IDX_W-1:0]       w_hit_idx;
  logic [NUM_REGIONS-1:0] w_hit_onehot;
  logic                   w_req;
  logic                   w_bad_req;
  logic [CNT_W-1:0]       w_wait;
  logic                   w_sel_ready;
  logic [DATA_W-1:0]      w_sel_rdata;
  logic                   w_complete;
  logic [7:0]             w_fault_count_nxt;

  // Address decode. Scanning from the top index down lets the lowest-index
  // hit overwrite any higher one, so overlapping regions resolve to the
  // lowest index.
  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_hit_onehot = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((m_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit           = 1'b1;
        w_hit_idx       = IDX_W'(i);
        w_hit_onehot    = '0;
        w_hit_onehot[i] = 1'b1;
      end
    end
  end

  assign w_req     = m_rd | m_wr;
  // Conflicting direction or an unmapped address never reaches a subordinate.
  assign w_bad_req = (m_rd & m_wr) | ~w_hit;

  // Per-access values for the region latched at request time.
  assign w_wait      = CNT_W'(REGION_WAIT[r_idx*4 +: 4]);
  assign w_sel_ready = s_ready[r_idx];
  assign w_sel_rdata = s_rdata[r_idx*DATA_W +: DATA_W];
  assign w_complete  = (r_cnt >= w_wait) && w_sel_ready;

  assign w_fault_count_nxt = (r_fault_count == 8'hFF) ? r_fault_count : r_fault_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_sel         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_s_rd        <= 1'b0;
      r_s_wr        <= 1'b0;
      r_rdata       <= OPEN_BUS;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b0;
          r_fault <= 1'b0;
          if (w_req) begin
            // Address and data are latched so the master may change them
            // while the access is in flight.
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_idx   <= w_hit_idx;
            if (w_bad_req) begin
              // Decode fault: answer immediately, writes are dropped.
              r_rdata       <= OPEN_BUS;
              r_ready       <= 1'b1;
              r_fault       <= 1'b1;
              r_fault_count <= w_fault_count_nxt;
              r_state       <= ST_DONE;
            end else begin
              r_sel   <= w_hit_onehot;
              r_s_rd  <= m_rd;
              r_s_wr  <= m_wr;
              r_cnt   <= '0;
              r_state <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          if (w_complete) begin
            // Writes leave the previous read data untouched.
            if (r_s_rd) begin
              r_rdata <= w_sel_rdata;
            end
            r_ready <= 1'b1;
            r_sel   <= '0;
            r_s_rd  <= 1'b0;
            r_s_wr  <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= ST_DONE;
          end else if (r_cnt == LAST_CNT) begin
            // TIMEOUT cycles spent in ACCESS without completion.
            r_rdata       <= OPEN_BUS;
            r_ready       <= 1'b1;
            r_fault       <= 1'b1;
            r_fault_count <= w_fault_count_nxt;
            r_sel         <= '0;
            r_s_rd        <= 1'b0;
            r_s_wr        <= 1'b0;
            r_cnt         <= r_cnt + 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // Single completion cycle; a request still held here is the one
          // just answered and must not start a second access.
          r_ready <= 1'b0;
          r_fault <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_ready <= 1'b0;
          r_fault <= 1'b0;
          r_sel   <= '0;
          r_s_rd  <= 1'b0;
          r_s_wr  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_rdata     = r_rdata;
  assign m_ready     = r_ready;
  assign m_fault     = r_fault;
  assign s_sel       = r_sel;
  assign s_addr      = r_addr;
  assign s_wdata     = r_wdata;
  assign s_rd        = r_s_rd;
  assign s_wr        = r_s_wr;
  assign fault_count = r_fault_count;

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
Parametrised memory-mapped interconnect between the CPU bus master and up to NUM_REGIONS subordinates (boot ROM, WRAM banks, AVR bridge, LED/GPIO registers). It replaces shared tri-state read data and free-running enables with:
- registered address decode and per-region selects;
- a registered read-data multiplexer;
- programmable per-region wait states and subordinate ready handshake;
- a bus-timeout/fault monitor with open-bus read value.

Parameters:
NUM_REGIONS, 4, number of subordinate regions (1..8)
ADDR_W, 16, address width
DATA_W, 8, data width
REGION_BASE, {16'hFFFF,16'hD000,16'hC000,16'h0000}, packed NUM_REGIONS*ADDR_W base addresses; region i at bits [i*ADDR_W +: ADDR_W]
REGION_MASK, {16'hFFFF,16'hF000,16'hF000,16'hC000}, packed match masks; hit_i = ((addr & MASK_i) == BASE_i)
REGION_WAIT, {4'd0,4'd1,4'd1,4'd1}, packed 4-bit minimum wait cycles per region
TIMEOUT, 16, maximum cycles in ACCESS before fault (must exceed every REGION_WAIT)
OPEN_BUS, 8'hFF, read data returned on unmapped/faulted access

Ports:
clk  in  1  bus clock
rst  in  1  reset, synchronous, active-high
m_addr  in  ADDR_W  master address
m_wdata  in  DATA_W  master write data
m_rd  in  1  master read request, held until m_ready
m_wr  in  1  master write request, held until m_ready
m_rdata  out  DATA_W  registered read data, valid while m_ready=1
m_ready  out  1  one-cycle completion pulse
m_fault  out  1  one-cycle fault pulse, coincident with m_ready
s_sel  out  NUM_REGIONS  one-hot registered subordinate select
s_addr  out  ADDR_W  latched address to subordinates
s_wdata  out  DATA_W  latched write data
s_rd  out  1  latched read strobe, qualified by s_sel
s_wr  out  1  latched write strobe, qualified by s_sel
s_rdata  in  NUM_REGIONS*DATA_W  per-region read data, region i at [i*DATA_W +: DATA_W]
s_ready  in  NUM_REGIONS  per-region ready; tie high for fixed-latency subordinates
fault_count  out  8  saturating count of faults since reset

Behaviour:
- Reset values: m_ready=0, m_fault=0, m_rdata=OPEN_BUS, s_sel=0, s_rd=0, s_wr=0, s_addr=0, s_wdata=0, fault_count=0, state=IDLE, wait counter=0. Reset mid-access aborts it immediately; no m_ready is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On (m_rd|m_wr), latch addr, wdata and direction.
  - Compute hits. The lowest-index hit wins on overlap.
  - m_rd and m_wr both high, or no hit: go to DONE with m_fault=1, m_ready=1, m_rdata=OPEN_BUS. No s_sel asserted; writes are dropped.
  - Otherwise: assert s_sel[i], s_rd/s_wr; clear counter; go to ACCESS.
- ACCESS:
  - Counter increments each cycle.
  - Completes on the first cycle where counter >= REGION_WAIT[i] and s_ready[i]=1.
  - On completion: m_rdata <= s_rdata[i] for reads (unchanged for writes), m_ready=1 next cycle, deassert s_sel/s_rd/s_wr, go to DONE.
  - If counter reaches TIMEOUT first: deassert selects, m_rdata=OPEN_BUS, m_ready=1, m_fault=1, go to DONE.
- DONE:
  - m_ready/m_fault high for exactly this one cycle.
  - Requests are ignored, so a request still held this cycle is not re-issued.
  - Return to IDLE.
- Latency: zero-wait subordinate with s_ready=1 gives request seen at cycle T, s_sel at T+1, m_ready at T+2. Each wait state adds one cycle.
- s_wr is high for the whole ACCESS phase; subordinates must commit the write once (at s_ready) or be idempotent.
- fault_count increments once per fault and saturates at 255.
- m_addr/m_wdata changes during ACCESS are ignored because the values are latched.

Test Plan:
- Read 0x0100 with ROM region 0 (wait 1, s_ready=1, s_rdata0=0x3C) -> s_sel=4'b0001 for 2 cycles; m_ready at T+3; m_rdata=0x3C; m_fault=0.
- Write 0xA5 to 0xFFFF (region 3, wait 0) -> s_sel=4'b1000, s_wr=1, s_wdata=0xA5 for 1 cycle; m_ready at T+2; request held through DONE produces no second write.
- Read 0xE000 (unmapped) -> no s_sel; m_ready=1, m_fault=1, m_rdata=0xFF at T+1; fault_count=1.
- Read 0xC010 with s_ready1 held low -> m_ready and m_fault after TIMEOUT=16 ACCESS cycles; m_rdata=0xFF; s_sel drops the same cycle.
- m_rd and m_wr both asserted at 0xC000 -> fault, no s_wr; overlapping regions 0 and 1 on an address -> region 0 selected.
- Assert rst during ACCESS -> next cycle all outputs at reset values; no m_ready; a following read completes normally.
